// File: rtl/series_eval.sv
`default_nettype none
// ============================================================================
// Module   : series_eval
// Purpose  : Sequential fixed-point power-series evaluator (exp/cos/sin style)
//            driven by an external coefficient LUT. Optional saturation of the
//            accumulator is enabled with macro SERIES_EVAL_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module series_eval #(
    parameter int  W     = 16,
    parameter int  FRAC  = 14,
    parameter int  TERMS = 8,
    localparam int CW    = $clog2(TERMS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic signed [W-1:0] x,
    input  logic [2:0]          mode,
    input  logic signed [W-1:0] coef,
    output logic [CW-1:0]       coef_idx,
    output logic signed [W-1:0] y,
    output logic                ready,
    output logic                done,
    output logic                ovf
);

    localparam logic signed [W-1:0] C_ONE = W'(1 << FRAC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_MUL1  = 3'd3,
        S_MUL2  = 3'd4,
        S_ACC   = 3'd5,
        S_CHECK = 3'd6
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_sign;
    logic                  r_alt;
    logic signed [W-1:0]   r_p;
    logic signed [W-1:0]   r_a;
    logic signed [W-1:0]   r_r;
    logic signed [W-1:0]   r_y;
    logic                  r_done;
    logic signed [W-1:0]   w_acc;
    logic                  w_sub;
    logic signed [W-1:0]   w_seed;

    // Full-width signed product, rescaled by FRAC and truncated back to W bits.
    function automatic logic signed [W-1:0] fx_mul(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        logic signed [2*W-1:0] full;
        full = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return W'(full >>> FRAC);
    endfunction

    assign w_sub  = r_alt && !r_sign;
    assign w_seed = mode[2] ? x : C_ONE;

`ifdef SERIES_EVAL_SAT_EN
    logic                r_ovf;
    logic signed [W:0]   w_sum;
    logic                w_acc_ovf;

    always_comb begin
        w_sum     = w_sub ? ({r_r[W-1], r_r} - {r_a[W-1], r_a})
                          : ({r_r[W-1], r_r} + {r_a[W-1], r_a});
        w_acc_ovf = (w_sum[W] != w_sum[W-1]);
        w_acc     = w_sum[W-1:0];
        if (w_acc_ovf)
            w_acc = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    assign ovf = r_ovf;
`else
    always_comb begin
        w_acc = w_sub ? (r_r - r_a) : (r_r + r_a);
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_alt   <= 1'b0;
            r_p     <= '0;
            r_a     <= '0;
            r_r     <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
`ifdef SERIES_EVAL_SAT_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start)
                        r_state <= S_INIT;
                end
                S_INIT: begin
                    r_cnt  <= '0;
                    r_sign <= 1'b0;
`ifdef SERIES_EVAL_SAT_EN
                    r_ovf  <= 1'b0;
`endif
                    if (!start)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_alt   <= mode[1];
                    r_p     <= mode[0] ? fx_mul(x, x) : x;
                    r_a     <= w_seed;
                    r_r     <= w_seed;
                    r_state <= S_MUL1;
                end
                S_MUL1: begin
                    r_a     <= fx_mul(r_a, r_p);
                    r_state <= S_MUL2;
                end
                S_MUL2: begin
                    r_a     <= fx_mul(r_a, coef);
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_r <= w_acc;
                    if (r_alt)
                        r_sign <= ~r_sign;
`ifdef SERIES_EVAL_SAT_EN
                    if (w_acc_ovf)
                        r_ovf <= 1'b1;
`endif
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    // stop is honoured only here, so y always holds a whole partial sum
                    if (r_cnt == CW'(TERMS) || stop) begin
                        r_y     <= r_r;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_MUL1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign coef_idx = r_cnt;
    assign y        = r_y;
    assign done     = r_done;
    assign ready    = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: doc/series_eval.md
SERIES_EVAL -- requirements
Module: series_eval

Interface
REQ-001 Parameter W, default 16, data width of signed fixed-point operands and result.
REQ-002 Parameter FRAC, default 14, fractional bits (1.0 = 2^FRAC).
REQ-003 Parameter TERMS, default 8, number of series terms accumulated after the seed (1..255).
REQ-004 Local CW = $clog2(TERMS+1), counter and coef_idx width.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  request, level-held by host.
REQ-008 stop  in  1  abort request, sampled in CHECK only.
REQ-009 x  in  W  signed operand.
REQ-010 mode  in  3  {seed_x, alt, pow2}, latched with x.
REQ-011 coef  in  W  signed coefficient, combinational from external LUT at coef_idx.
REQ-012 coef_idx  out  CW  current term index (0-based).
REQ-013 y  out  W  signed result register.
REQ-014 ready  out  1  high only in IDLE.
REQ-015 done  out  1  one-cycle pulse on return to IDLE after a run.
REQ-016 ovf  out  1  sticky accumulator overflow flag.

Function
REQ-017 FSM states IDLE, INIT, LOAD, MUL1, MUL2, ACC, CHECK shall be used.
REQ-018 IDLE -> INIT when start=1; INIT shall hold while start=1 and go to LOAD when start=0.
REQ-019 INIT shall clear cnt, sign flag, ovf; LOAD shall latch x and mode, set P = pow2 ? x*x : x, seed S = seed_x ? x : 1.0, A <= S, R <= S.
REQ-020 MUL1: A <= A*P; MUL2: A <= A*coef[cnt], cnt <= cnt+1; coef_idx shall equal cnt.
REQ-021 Products: full 2W signed, arithmetic shift right FRAC, truncated to W.
REQ-022 ACC: R <= (alt & ~sign) ? R-A : R+A; sign toggles when alt=1, first accumulated term is subtracted.
REQ-023 CHECK: if cnt==TERMS or stop=1 -> IDLE, y <= R, done=1 that cycle; else -> MUL1.
REQ-024 Latency: LOAD + 4*TERMS cycles from start deassertion to IDLE; stop shortens run at next CHECK, y holds partial sum.
REQ-025 start asserted during a run shall be ignored; y shall hold last result until next run completes.
REQ-026 ready=1 in IDLE only; all other control outputs decoded from state, no latches.

Reset
REQ-027 rst=0 at any time, including mid-run, shall force IDLE, cnt=0, A=R=0, y=0, done=0, ovf=0, ready=1 on the next evaluation without a clock edge.
REQ-028 After rst release, first transition shall require start=1 sampled on a rising clk.

Configuration
REQ-029 Macro SERIES_EVAL_SAT_EN defined: ACC result exceeding W-bit signed range shall saturate to 2^(W-1)-1 or -2^(W-1) and set ovf sticky until INIT or reset.
REQ-030 Macro undefined: ACC shall wrap two's complement and ovf shall be constant 0.

Verification (W=16, FRAC=14, TERMS=8)
REQ-031 exp: x=8192, mode=000, coef[k]=16384/(k+1) -> after 33 cycles y=27013 +/-8, done one pulse, ovf=0.
REQ-032 cos: x=8192, mode=011, coef[k]=16384/((2k+1)(2k+2)) -> y=14378 +/-8.
REQ-033 sin: x=8192, mode=111, coef[k]=16384/((2k+2)(2k+3)) -> y=7855 +/-8.
REQ-034 stop=1 at first CHECK, exp x=8192 -> IDLE after 5 cycles, y=24576 +/-2.
REQ-035 exp x=31130 (1.9) with SAT_EN -> y=32767, ovf=1; without -> wrapped value, ovf=0.
REQ-036 start held 5 cycles -> INIT held 5 cycles; rst=0 during MUL2 -> immediate IDLE, ready=1, y=0.
